// File: rtl/student_tlul_reg_adapter.sv
`default_nettype none
// ============================================================================
// Module      : tlul_pkg / student_tlul_reg_adapter
// Description : The package holds the TL-UL channel structs and opcodes.
//               The module is a TL-UL device-side adapter for one output
//               port of the address mux. It accepts one request at a time and
//               turns it into a one-cycle register-bus strobe (re_o / we_o).
//               It then returns the D-channel response. Malformed requests
//               and devices that never answer are turned into error
//               responses so the host never stalls.
// Ports       : clk_i, rst_ni       - clock, synchronous active-low reset
//               tl_i / tl_o         - TL-UL request in / response out
//               re_o / we_o         - one-cycle read / write strobes
//               addr_o, wdata_o,
//               be_o                - registered byte address, data, enables
//               rdata_i, rvalid_i,
//               error_i             - device read data, valid, error
// Revision    : 1.0 - initial release
// ============================================================================

package tlul_pkg;

    localparam logic [2:0] c_put_full_data    = 3'd0;
    localparam logic [2:0] c_put_partial_data = 3'd1;
    localparam logic [2:0] c_get              = 3'd4;
    localparam logic [2:0] c_access_ack       = 3'd0;
    localparam logic [2:0] c_access_ack_data  = 3'd1;

    typedef struct packed {
        logic        a_valid;
        logic [2:0]  a_opcode;
        logic [2:0]  a_param;
        logic [1:0]  a_size;
        logic [7:0]  a_source;
        logic [31:0] a_address;
        logic [3:0]  a_mask;
        logic [31:0] a_data;
        logic [15:0] a_user;
        logic        d_ready;
    } tl_h2d_t;

    typedef struct packed {
        logic        d_valid;
        logic [2:0]  d_opcode;
        logic [2:0]  d_param;
        logic [1:0]  d_size;
        logic [7:0]  d_source;
        logic [0:0]  d_sink;
        logic [31:0] d_data;
        logic [15:0] d_user;
        logic        d_error;
        logic        a_ready;
    } tl_d2h_t;

endpackage

module student_tlul_reg_adapter #(
    parameter int ADDR_W  = 20,
    parameter int TIMEOUT = 16
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  tlul_pkg::tl_h2d_t  tl_i,
    output tlul_pkg::tl_d2h_t  tl_o,
    output logic               re_o,
    output logic               we_o,
    output logic [ADDR_W-1:0]  addr_o,
    output logic [31:0]        wdata_o,
    output logic [3:0]         be_o,
    input  logic [31:0]        rdata_i,
    input  logic               rvalid_i,
    input  logic               error_i
);

    import tlul_pkg::*;

    // Wide enough to hold TIMEOUT-1 even when TIMEOUT is 1.
    localparam int CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] c_cnt_last = CNT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } state_e;

    state_e             r_state;
    state_e             w_state_next;

    logic               r_is_get;
    logic               r_re;
    logic               r_we;
    logic [ADDR_W-1:0]  r_addr;
    logic [31:0]        r_wdata;
    logic [3:0]         r_be;
    logic [CNT_W-1:0]   r_cnt;

    logic               r_d_valid;
    logic [2:0]         r_d_opcode;
    logic [1:0]         r_d_size;
    logic [7:0]         r_d_source;
    logic [31:0]        r_d_data;
    logic               r_d_error;

    logic               w_a_ready;
    logic               w_accept;
    logic               w_op_legal;
    logic               w_bad;
    logic               w_timeout;
    logic               w_unused;

    // ------------------------------------------------------------------
    // Request decode
    // ------------------------------------------------------------------
    assign w_a_ready = (r_state == ST_IDLE) && rst_ni;
    assign w_accept  = tl_i.a_valid && w_a_ready;

    assign w_op_legal = (tl_i.a_opcode == c_get)
                     || (tl_i.a_opcode == c_put_full_data)
                     || (tl_i.a_opcode == c_put_partial_data);

    // Misaligned sub-word and oversize accesses are rejected without
    // touching the register bus.
    assign w_bad = !w_op_legal
                || (tl_i.a_size > 2'd2)
                || ((tl_i.a_size == 2'd1) && tl_i.a_address[0])
                || ((tl_i.a_size == 2'd2) && (tl_i.a_address[1:0] != 2'b00));

    assign w_timeout = (r_cnt == c_cnt_last);

    // Fields that this device never looks at. The upper address bits have
    // already been consumed by the mux.
    assign w_unused = ^{tl_i.a_param, tl_i.a_user, tl_i.a_address};

    // ------------------------------------------------------------------
    // State machine
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_state_next = w_bad ? ST_RESP : ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (r_is_get && !rvalid_i) begin
                    w_state_next = ST_WAIT;
                end else begin
                    w_state_next = ST_RESP;
                end
            end
            ST_WAIT: begin
                if (rvalid_i || w_timeout) begin
                    w_state_next = ST_RESP;
                end
            end
            ST_RESP: begin
                if (tl_i.d_ready) begin
                    w_state_next = ST_IDLE;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath: request capture, strobes, response registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_is_get   <= 1'b0;
            r_re       <= 1'b0;
            r_we       <= 1'b0;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_be       <= '0;
            r_cnt      <= '0;
            r_d_valid  <= 1'b0;
            r_d_opcode <= '0;
            r_d_size   <= '0;
            r_d_source <= '0;
            r_d_data   <= '0;
            r_d_error  <= 1'b0;
        end else begin
            // Strobes are single-cycle by construction.
            r_re <= 1'b0;
            r_we <= 1'b0;

            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_is_get   <= (tl_i.a_opcode == c_get);
                        r_addr     <= tl_i.a_address[ADDR_W-1:0];
                        r_wdata    <= tl_i.a_data;
                        r_be       <= tl_i.a_mask;
                        r_d_size   <= tl_i.a_size;
                        r_d_source <= tl_i.a_source;
                        r_d_opcode <= (tl_i.a_opcode == c_get) ? c_access_ack_data
                                                               : c_access_ack;
                        r_d_data   <= '0;
                        r_d_error  <= w_bad;
                        if (w_bad) begin
                            r_d_valid <= 1'b1;
                        end else if (tl_i.a_opcode == c_get) begin
                            r_re <= 1'b1;
                        end else begin
                            r_we <= 1'b1;
                        end
                    end
                end
                ST_ISSUE: begin
                    if (r_is_get) begin
                        if (rvalid_i) begin
                            r_d_data  <= error_i ? 32'h0 : rdata_i;
                            r_d_error <= error_i;
                            r_d_valid <= 1'b1;
                        end else begin
                            r_cnt <= '0;
                        end
                    end else begin
                        r_d_error <= error_i;
                        r_d_valid <= 1'b1;
                    end
                end
                ST_WAIT: begin
                    r_cnt <= r_cnt + 1'b1;
                    // Data arriving on the last allowed cycle still counts.
                    if (rvalid_i) begin
                        r_d_data  <= error_i ? 32'h0 : rdata_i;
                        r_d_error <= error_i;
                        r_d_valid <= 1'b1;
                    end else if (w_timeout) begin
                        r_d_data  <= '0;
                        r_d_error <= 1'b1;
                        r_d_valid <= 1'b1;
                    end
                end
                ST_RESP: begin
                    if (tl_i.d_ready) begin
                        r_d_valid <= 1'b0;
                    end
                end
                default: r_d_valid <= 1'b0;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign re_o    = r_re;
    assign we_o    = r_we;
    assign addr_o  = r_addr;
    assign wdata_o = r_wdata;
    assign be_o    = r_be;

    assign tl_o.d_valid  = r_d_valid;
    assign tl_o.d_opcode = r_d_opcode;
    assign tl_o.d_param  = 3'd0;
    assign tl_o.d_size   = r_d_size;
    assign tl_o.d_source = r_d_source;
    assign tl_o.d_sink   = 1'b0;
    assign tl_o.d_data   = r_d_data;
    assign tl_o.d_user   = 16'd0;
    assign tl_o.d_error  = r_d_error;
    assign tl_o.a_ready  = w_a_ready;

endmodule

`default_nettype wire

// File: tb/tb_student_tlul_reg_adapter.sv
`default_nettype none
// ============================================================================
// Module      : tb_student_tlul_reg_adapter
// Description : Directed self-checking bench for student_tlul_reg_adapter.
//               It covers writes, immediate and delayed reads, timeout and
//               its boundary, malformed requests, backpressure and reset
//               during a pending read.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_student_tlul_reg_adapter;

    import tlul_pkg::*;

    logic        clk_i;
    logic        rst_ni;
    tl_h2d_t     h2d;
    tl_d2h_t     d2h;
    logic        re_o;
    logic        we_o;
    logic [19:0] addr_o;
    logic [31:0] wdata_o;
    logic [3:0]  be_o;
    logic [31:0] rdata_i;
    logic        rvalid_i;
    logic        error_i;

    int checks;
    int errors;

    student_tlul_reg_adapter #(
        .ADDR_W  (20),
        .TIMEOUT (16)
    ) dut (
        .clk_i    (clk_i),
        .rst_ni   (rst_ni),
        .tl_i     (h2d),
        .tl_o     (d2h),
        .re_o     (re_o),
        .we_o     (we_o),
        .addr_o   (addr_o),
        .wdata_o  (wdata_o),
        .be_o     (be_o),
        .rdata_i  (rdata_i),
        .rvalid_i (rvalid_i),
        .error_i  (error_i)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    // Step to 1 ns after the next rising edge: outputs are settled there.
    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    // Present one request for exactly one cycle. On return the bench sits in
    // cycle T+1, where T is the accepting cycle.
    task automatic send(input logic [2:0] op, input logic [1:0] size,
                        input logic [31:0] addr, input logic [31:0] data,
                        input logic [3:0] mask, input logic [7:0] src);
        h2d.a_valid   = 1'b1;
        h2d.a_opcode  = op;
        h2d.a_size    = size;
        h2d.a_address = addr;
        h2d.a_data    = data;
        h2d.a_mask    = mask;
        h2d.a_source  = src;
        tick();
        h2d.a_valid   = 1'b0;
    endtask

    task automatic test_reset();
        rst_ni = 1'b0;
        tick();
        tick();
        checks++; if (d2h.a_ready !== 1'b0) begin errors++; $display("FAIL rst_a_ready: got %0b want 0", d2h.a_ready); end
        checks++; if (d2h.d_valid !== 1'b0) begin errors++; $display("FAIL rst_d_valid: got %0b want 0", d2h.d_valid); end
        checks++; if ({re_o, we_o} !== 2'b00) begin errors++; $display("FAIL rst_strobes: got %b want 00", {re_o, we_o}); end
        checks++; if ({addr_o, wdata_o, be_o} !== 56'h0) begin errors++; $display("FAIL rst_regs: got %h want 0", {addr_o, wdata_o, be_o}); end
        checks++; if ({d2h.d_opcode, d2h.d_size, d2h.d_source, d2h.d_data, d2h.d_error} !== 46'h0) begin
            errors++; $display("FAIL rst_d_fields: got %h want 0", {d2h.d_opcode, d2h.d_size, d2h.d_source, d2h.d_data, d2h.d_error});
        end
        rst_ni = 1'b1;
        tick();
        checks++; if (d2h.a_ready !== 1'b1) begin errors++; $display("FAIL rst_release_a_ready: got %0b want 1", d2h.a_ready); end
    endtask

    task automatic test_write();
        send(c_put_full_data, 2'd2, 32'h0000_0010, 32'hCAFE_F00D, 4'hF, 8'd5);
        // T+1
        checks++; if ({re_o, we_o} !== 2'b01) begin errors++; $display("FAIL wr_strobe: got re/we %b want 01", {re_o, we_o}); end
        checks++; if (addr_o !== 20'h00010) begin errors++; $display("FAIL wr_addr: got %h want 00010", addr_o); end
        checks++; if (be_o !== 4'hF) begin errors++; $display("FAIL wr_be: got %h want f", be_o); end
        checks++; if (wdata_o !== 32'hCAFE_F00D) begin errors++; $display("FAIL wr_wdata: got %h want cafef00d", wdata_o); end
        checks++; if ({d2h.a_ready, d2h.d_valid} !== 2'b00) begin errors++; $display("FAIL wr_t1_handshake: got %b want 00", {d2h.a_ready, d2h.d_valid}); end
        tick();
        // T+2
        checks++; if (we_o !== 1'b0) begin errors++; $display("FAIL wr_strobe_len: got we %0b want 0", we_o); end
        checks++; if (d2h.d_valid !== 1'b1) begin errors++; $display("FAIL wr_d_valid: got %0b want 1", d2h.d_valid); end
        checks++; if ({d2h.d_opcode, d2h.d_source, d2h.d_size, d2h.d_error} !== {3'd0, 8'd5, 2'd2, 1'b0}) begin
            errors++; $display("FAIL wr_resp: got op %0d src %0d size %0d err %0b want op 0 src 5 size 2 err 0", d2h.d_opcode, d2h.d_source, d2h.d_size, d2h.d_error);
        end
        checks++; if ({d2h.d_data, d2h.d_param, d2h.d_sink, d2h.d_user} !== 52'h0) begin
            errors++; $display("FAIL wr_zero_fields: got %h want 0", {d2h.d_data, d2h.d_param, d2h.d_sink, d2h.d_user});
        end
        tick();
        // T+3: back in IDLE, ready for the next accept
        checks++; if ({d2h.a_ready, d2h.d_valid} !== 2'b10) begin errors++; $display("FAIL wr_t3_idle: got a_ready/d_valid %b want 10", {d2h.a_ready, d2h.d_valid}); end
        checks++; if (addr_o !== 20'h00010) begin errors++; $display("FAIL wr_addr_hold: got %h want 00010", addr_o); end
    endtask

    task automatic test_back_to_back();
        // Accept immediately at T+3 of the previous write: same-cycle read.
        send(c_get, 2'd2, 32'h0000_0008, 32'h0, 4'hF, 8'd2);
        rvalid_i = 1'b1;
        rdata_i  = 32'hA5A5_0001;
        checks++; if (re_o !== 1'b1) begin errors++; $display("FAIL b2b_re: got %0b want 1", re_o); end
        tick();
        rvalid_i = 1'b0;
        checks++; if ({d2h.d_valid, d2h.d_opcode, d2h.d_error} !== {1'b1, 3'd1, 1'b0}) begin
            errors++; $display("FAIL b2b_resp: got valid %0b op %0d err %0b want 1 1 0", d2h.d_valid, d2h.d_opcode, d2h.d_error);
        end
        checks++; if (d2h.d_data !== 32'hA5A5_0001) begin errors++; $display("FAIL b2b_data: got %h want a5a50001", d2h.d_data); end
        tick();
    endtask

    task automatic test_read_delayed();
        send(c_get, 2'd2, 32'h0000_0004, 32'h0, 4'hF, 8'd3);
        checks++; if ({re_o, we_o} !== 2'b10) begin errors++; $display("FAIL rd_strobe: got re/we %b want 10", {re_o, we_o}); end
        checks++; if (addr_o !== 20'h00004) begin errors++; $display("FAIL rd_addr: got %h want 00004", addr_o); end
        for (int k = 2; k <= 4; k++) begin
            tick();
            checks++; if (d2h.d_valid !== 1'b0) begin errors++; $display("FAIL rd_early_valid: cycle T+%0d got 1 want 0", k); end
        end
        // T+4: data arrives three cycles after the strobe
        rvalid_i = 1'b1;
        rdata_i  = 32'h1234_5678;
        tick();
        rvalid_i = 1'b0;
        rdata_i  = 32'h0;
        // T+5
        checks++; if (d2h.d_valid !== 1'b1) begin errors++; $display("FAIL rd_d_valid: got %0b want 1", d2h.d_valid); end
        checks++; if ({d2h.d_opcode, d2h.d_source, d2h.d_error} !== {3'd1, 8'd3, 1'b0}) begin
            errors++; $display("FAIL rd_resp: got op %0d src %0d err %0b want 1 3 0", d2h.d_opcode, d2h.d_source, d2h.d_error);
        end
        checks++; if (d2h.d_data !== 32'h1234_5678) begin errors++; $display("FAIL rd_data: got %h want 12345678", d2h.d_data); end
        tick();
    endtask

    task automatic test_timeout();
        send(c_get, 2'd2, 32'h0000_0008, 32'h0, 4'hF, 8'd7);
        for (int k = 2; k <= 17; k++) begin
            tick();
            checks++; if (d2h.d_valid !== 1'b0) begin errors++; $display("FAIL to_early_valid: cycle T+%0d got 1 want 0", k); end
        end
        tick();
        // T+18
        checks++; if ({d2h.d_valid, d2h.d_error, d2h.d_opcode} !== {1'b1, 1'b1, 3'd1}) begin
            errors++; $display("FAIL to_resp: got valid %0b err %0b op %0d want 1 1 1", d2h.d_valid, d2h.d_error, d2h.d_opcode);
        end
        checks++; if (d2h.d_data !== 32'h0) begin errors++; $display("FAIL to_data: got %h want 0", d2h.d_data); end
        tick();
        // Late data after the timeout must be dropped.
        rvalid_i = 1'b1;
        rdata_i  = 32'hDEAD_BEEF;
        tick();
        tick();
        rvalid_i = 1'b0;
        checks++; if ({d2h.d_valid, d2h.a_ready} !== 2'b01) begin errors++; $display("FAIL to_late_rvalid: got d_valid/a_ready %b want 01", {d2h.d_valid, d2h.a_ready}); end
    endtask

    task automatic test_timeout_edge();
        send(c_get, 2'd2, 32'h0000_000C, 32'h0, 4'hF, 8'd8);
        for (int k = 2; k <= 16; k++) tick();
        tick();
        // T+17: last WAIT cycle, data and timeout coincide
        rvalid_i = 1'b1;
        rdata_i  = 32'h5555_AAAA;
        tick();
        rvalid_i = 1'b0;
        checks++; if ({d2h.d_valid, d2h.d_error} !== 2'b10) begin errors++; $display("FAIL toe_resp: got valid/err %b want 10", {d2h.d_valid, d2h.d_error}); end
        checks++; if (d2h.d_data !== 32'h5555_AAAA) begin errors++; $display("FAIL toe_data: got %h want 5555aaaa", d2h.d_data); end
        tick();
    endtask

    task automatic test_write_error();
        send(c_put_partial_data, 2'd0, 32'h0000_0003, 32'h7700_0000, 4'h8, 8'd4);
        error_i = 1'b1;
        checks++; if ({we_o, be_o} !== 5'b1_1000) begin errors++; $display("FAIL we_err_strobe: got we/be %b want 11000", {we_o, be_o}); end
        tick();
        error_i = 1'b0;
        checks++; if ({d2h.d_valid, d2h.d_error, d2h.d_opcode} !== {1'b1, 1'b1, 3'd0}) begin
            errors++; $display("FAIL we_err_resp: got valid %0b err %0b op %0d want 1 1 0", d2h.d_valid, d2h.d_error, d2h.d_opcode);
        end
        tick();
    endtask

    task automatic test_malformed();
        logic [2:0]  m_op   [4];
        logic [1:0]  m_size [4];
        logic [31:0] m_addr [4];
        logic [2:0]  m_dop  [4];
        m_op[0] = 3'd7;  m_size[0] = 2'd2; m_addr[0] = 32'h0; m_dop[0] = 3'd0;
        m_op[1] = 3'd4;  m_size[1] = 2'd2; m_addr[1] = 32'h2; m_dop[1] = 3'd1;
        m_op[2] = 3'd4;  m_size[2] = 2'd3; m_addr[2] = 32'h0; m_dop[2] = 3'd1;
        m_op[3] = 3'd1;  m_size[3] = 2'd1; m_addr[3] = 32'h1; m_dop[3] = 3'd0;
        for (int i = 0; i < 4; i++) begin
            send(m_op[i], m_size[i], m_addr[i], 32'hFFFF_FFFF, 4'hF, 8'(10 + i));
            checks++; if ({d2h.d_valid, d2h.d_error, re_o, we_o} !== 4'b1100) begin
                errors++; $display("FAIL bad%0d_resp: got valid/err/re/we %b want 1100", i, {d2h.d_valid, d2h.d_error, re_o, we_o});
            end
            checks++; if ({d2h.d_opcode, d2h.d_source, d2h.d_data} !== {m_dop[i], 8'(10 + i), 32'h0}) begin
                errors++; $display("FAIL bad%0d_fields: got op %0d src %0d data %h want op %0d src %0d data 0", i, d2h.d_opcode, d2h.d_source, d2h.d_data, m_dop[i], 10 + i);
            end
            tick();
            checks++; if ({d2h.d_valid, d2h.a_ready, re_o, we_o} !== 4'b0100) begin
                errors++; $display("FAIL bad%0d_after: got valid/a_ready/re/we %b want 0100", i, {d2h.d_valid, d2h.a_ready, re_o, we_o});
            end
        end
    endtask

    task automatic test_backpressure();
        h2d.d_ready = 1'b0;
        send(c_get, 2'd2, 32'h0000_0010, 32'h0, 4'hF, 8'd6);
        rvalid_i = 1'b1;
        rdata_i  = 32'h0BAD_CAFE;
        tick();
        rvalid_i = 1'b0;
        rdata_i  = 32'h0;
        for (int k = 0; k < 10; k++) begin
            checks++; if ({d2h.d_valid, d2h.a_ready, d2h.d_data} !== {2'b10, 32'h0BAD_CAFE}) begin
                errors++; $display("FAIL bp_hold: step %0d got valid %0b a_ready %0b data %h want 1 0 0badcafe", k, d2h.d_valid, d2h.a_ready, d2h.d_data);
            end
            if (k < 9) tick();
        end
        h2d.d_ready = 1'b1;
        tick();
        checks++; if ({d2h.d_valid, d2h.a_ready} !== 2'b01) begin errors++; $display("FAIL bp_release: got d_valid/a_ready %b want 01", {d2h.d_valid, d2h.a_ready}); end
    endtask

    task automatic test_reset_mid();
        send(c_get, 2'd2, 32'h0000_0014, 32'h0, 4'hF, 8'd12);
        tick();
        tick();
        // T+3: waiting for data
        rst_ni = 1'b0;
        tick();
        checks++; if ({d2h.d_valid, d2h.a_ready, re_o, we_o} !== 4'b0000) begin
            errors++; $display("FAIL rm_ctrl: got valid/a_ready/re/we %b want 0000", {d2h.d_valid, d2h.a_ready, re_o, we_o});
        end
        checks++; if ({addr_o, wdata_o, be_o, d2h.d_source, d2h.d_opcode, d2h.d_error, d2h.d_data} !== 100'h0) begin
            errors++; $display("FAIL rm_regs: got %h want 0", {addr_o, wdata_o, be_o, d2h.d_source, d2h.d_opcode, d2h.d_error, d2h.d_data});
        end
        rst_ni = 1'b1;
        #1;
        checks++; if (d2h.a_ready !== 1'b1) begin errors++; $display("FAIL rm_a_ready: got %0b want 1", d2h.a_ready); end
        send(c_put_partial_data, 2'd1, 32'h0000_0020, 32'h1122_3344, 4'h3, 8'd9);
        checks++; if ({we_o, addr_o, be_o} !== {1'b1, 20'h00020, 4'h3}) begin
            errors++; $display("FAIL rm_put_strobe: got we %0b addr %h be %h want 1 00020 3", we_o, addr_o, be_o);
        end
        tick();
        checks++; if ({d2h.d_valid, d2h.d_error, d2h.d_source, d2h.d_size} !== {2'b10, 8'd9, 2'd1}) begin
            errors++; $display("FAIL rm_put_resp: got valid %0b err %0b src %0d size %0d want 1 0 9 1", d2h.d_valid, d2h.d_error, d2h.d_source, d2h.d_size);
        end
        tick();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        checks   = 0;
        errors   = 0;
        h2d      = '0;
        h2d.d_ready = 1'b1;
        rdata_i  = 32'h0;
        rvalid_i = 1'b0;
        error_i  = 1'b0;
        rst_ni   = 1'b0;

        test_reset();
        test_write();
        test_back_to_back();
        test_read_delayed();
        test_timeout();
        test_timeout_edge();
        test_write_error();
        test_malformed();
        test_backpressure();
        test_reset_mid();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
